hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the write-enable and flush of the IF/ID register and the PC.
- Injects bubbles into ID/EX and freezes the back end on data-memory wait.
- Resolves load-use hazards, taken branches (resolved in EX), jumps (decoded in ID) and memory stalls under one fixed priority.
- Keeps saturating stall/flush statistics.

## Interface
- LU_STALL_CYCLES, 1: bubble cycles per load-use hazard (1..15).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before mem_timeout_out sets (1..65535).
- clk  in  1  clock; all state updates on posedge.
- reset_in  in  1  reset, asynchronous, active-high.
- IF_ID_Rs_in  in  5  rs field of the instruction in ID.
- IF_ID_Rt_in  in  5  rt field of the instruction in ID.
- Op_code_in  in  6  opcode of the instruction in ID.
- ID_EX_MemRead_in  in  1  instruction in EX is a load.
- ID_EX_Rt_in  in  5  destination rt of the instruction in EX.
- branch_taken_in  in  1  branch in EX resolved taken this cycle.
- jump_in  in  1  jump decoded in ID this cycle.
- mem_busy_in  in  1  data memory not ready this cycle.
- PC_Write_out  out  1  PC may update.
- IF_ID_enable_out  out  1  IF/ID register captures.
- IF_ID_flush_out  out  1  IF/ID loads a NOP.
- ID_EX_bubble_out  out  1  ID/EX loads control zeros.
- pipe_hold_out  out  1  ID/EX, EX/MEM and MEM/WB hold their values.
- mem_timeout_out  out  1  sticky memory-timeout error.
- stall_count_out  out  16  cycles with PC_Write_out=0; saturates at 0xFFFF.
- flush_count_out  out  16  cycles with IF_ID_flush_out=1; saturates at 0xFFFF.

## Operation
- States: RUN, LU_STALL, MEM_WAIT. Also registered: 4-bit lu_cnt, saved return state ret_st, 16-bit wait_cnt.
- Outputs are combinational from state and the current inputs (Mealy). Defaults: PC_Write_out=1, IF_ID_enable_out=1, all other control outputs 0.
- uses_rt = Op_code_in is 0x00, 0x04, 0x05 or 0x2B.
- lu_hit = ID_EX_MemRead_in && ID_EX_Rt_in!=0 && (ID_EX_Rt_in==IF_ID_Rs_in || (uses_rt && ID_EX_Rt_in==IF_ID_Rt_in)).
- Priority is the same in RUN and LU_STALL, highest first:
  1. mem_busy_in: freeze. pipe_hold_out=1, PC_Write_out=0, IF_ID_enable_out=0, no flush, no bubble. Next state MEM_WAIT; ret_st takes the current state; wait_cnt=1.
  2. branch_taken_in: IF_ID_flush_out=1, ID_EX_bubble_out=1, PC_Write_out=1. Next state RUN; lu_cnt is cleared, which aborts any load-use stall.
  3. Stall condition: in RUN, lu_hit; in LU_STALL, always. Outputs PC_Write_out=0, IF_ID_enable_out=0, ID_EX_bubble_out=1.
     - From RUN: if LU_STALL_CYCLES>=2, go to LU_STALL with lu_cnt=LU_STALL_CYCLES-1; otherwise stay in RUN.
     - In LU_STALL: if lu_cnt==1, go to RUN; otherwise lu_cnt decrements.
  4. jump_in (RUN only): IF_ID_flush_out=1, PC_Write_out=1.
- MEM_WAIT behaviour:
  - While mem_busy_in=1: freeze outputs as in priority 1. wait_cnt increments and saturates. When wait_cnt reaches MEM_TIMEOUT, mem_timeout_out sets and stays set until reset. The state stays MEM_WAIT.
  - When mem_busy_in=0: the state returns to ret_st with lu_cnt preserved. The outputs in that cycle are evaluated as if the block were already in ret_st, using the RUN/LU_STALL priority list.
- A branch or jump arriving during MEM_WAIT is ignored. The frozen pipeline re-presents it after the wait.
- Statistics update every cycle that reset is low: stall_count_out increments when PC_Write_out=0; flush_count_out increments when IF_ID_flush_out=1. Both saturate.

## Timing
- Control outputs have zero latency: they respond in the same cycle as their inputs. State changes on the next posedge.
- A load-use hazard costs exactly LU_STALL_CYCLES cycles of PC_Write_out=0, unless a memory wait or a taken branch intervenes.
- A memory wait of N cycles at mem_busy_in=1 gives exactly N freeze cycles. The next cycle behaves as ret_st.
- While reset_in=1, asynchronously:
  - Registers: state=RUN, lu_cnt=0, ret_st=RUN, wait_cnt=0, mem_timeout_out=0, both counters 0.
  - Outputs: PC_Write_out=0, IF_ID_enable_out=0, IF_ID_flush_out=1, ID_EX_bubble_out=1, pipe_hold_out=0.
- Reset asserted mid-stall or mid-wait aborts the stall or wait immediately. After deassertion the block behaves as RUN.

## Test plan
- Load-use, LU_STALL_CYCLES=1: lw $2 in EX (ID_EX_MemRead_in=1, ID_EX_Rt_in=2); add with rs=2 in ID. Expected: exactly 1 cycle of PC_Write_out=0 and ID_EX_bubble_out=1; stall_count_out=1. Repeat with rs=0 and ID_EX_Rt_in=0: no stall. Repeat with lw in ID (opcode 0x23), rt=2: no stall.
- LU_STALL_CYCLES=3 with branch_taken_in pulsed in the 2nd stall cycle. Expected: that cycle shows flush=1, bubble=1, PC_Write_out=1; the next cycle is RUN with no stall; stall_count_out=1.
- mem_busy_in high for 4 cycles arriving in LU_STALL with lu_cnt=2. Expected: 4 cycles with pipe_hold_out=1, then 2 more stall cycles, then RUN.
- MEM_TIMEOUT=8 with mem_busy_in held 10 cycles. Expected: mem_timeout_out rises after the 8th wait cycle; it stays 1 after mem_busy_in drops and clears only on reset_in.
- jump_in and lu_hit in the same RUN cycle. Expected: the stall wins (no flush). Then jump_in alone gives 1 cycle of IF_ID_flush_out=1 and flush_count_out=1.
- Asynchronous reset mid-MEM_WAIT, asserted between clock edges. Expected: outputs take their reset values without waiting for a clock edge; counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the MIPS pipeline and its hazard/sequencing controller.
// The pipeline side (master) supplies decode/EX/memory status and consumes the
// register-enable, flush, bubble and hold controls; the controller is the slave.
interface hazard_ctrl_if;
    logic [4:0]  IF_ID_Rs_in;
    logic [4:0]  IF_ID_Rt_in;
    logic [5:0]  Op_code_in;
    logic        ID_EX_MemRead_in;
    logic [4:0]  ID_EX_Rt_in;
    logic        branch_taken_in;
    logic        jump_in;
    logic        mem_busy_in;
    logic        PC_Write_out;
    logic        IF_ID_enable_out;
    logic        IF_ID_flush_out;
    logic        ID_EX_bubble_out;
    logic        pipe_hold_out;
    logic        mem_timeout_out;
    logic [15:0] stall_count_out;
    logic [15:0] flush_count_out;

    modport master (
        output IF_ID_Rs_in, IF_ID_Rt_in, Op_code_in, ID_EX_MemRead_in, ID_EX_Rt_in,
               branch_taken_in, jump_in, mem_busy_in,
        input  PC_Write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out,
               pipe_hold_out, mem_timeout_out, stall_count_out, flush_count_out
    );

    modport slave (
        input  IF_ID_Rs_in, IF_ID_Rt_in, Op_code_in, ID_EX_MemRead_in, ID_EX_Rt_in,
               branch_taken_in, jump_in, mem_busy_in,
        output PC_Write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out,
               pipe_hold_out, mem_timeout_out, stall_count_out, flush_count_out
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Arbitrates memory freezes, taken branches, load-use stalls and jumps under a
// fixed priority and drives PC / IF/ID / ID/EX / back-end hold controls with
// zero latency (Mealy). Also keeps saturating stall and flush statistics.
module hazard_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          reset_in,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  LU_RELOAD   = 4'(LU_STALL_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    state_t      ret_st_q, ret_st_d;
    state_t      eff_st;
    logic [3:0]  lu_cnt_q, lu_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    logic        uses_rt, lu_hit, in_wait;
    logic        do_freeze, do_branch, do_stall, do_jump;
    logic        pc_write, if_id_en, if_id_flush, id_ex_bubble, hold;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Hazard detection and priority arbitration; a released memory wait is judged as its saved state.
    always_comb begin
        uses_rt = (bus.Op_code_in == 6'h00) || (bus.Op_code_in == 6'h04) ||
                  (bus.Op_code_in == 6'h05) || (bus.Op_code_in == 6'h2B);
        lu_hit  = bus.ID_EX_MemRead_in && (bus.ID_EX_Rt_in != 5'd0) &&
                  ((bus.ID_EX_Rt_in == bus.IF_ID_Rs_in) ||
                   (uses_rt && (bus.ID_EX_Rt_in == bus.IF_ID_Rt_in)));
        in_wait   = (state_q == MEM_WAIT);
        eff_st    = in_wait ? ret_st_q : state_q;
        do_freeze = bus.mem_busy_in;
        do_branch = !do_freeze && bus.branch_taken_in;
        do_stall  = !do_freeze && !bus.branch_taken_in &&
                    ((eff_st == LU_STALL) || ((eff_st == RUN) && lu_hit));
        do_jump   = !do_freeze && !bus.branch_taken_in && !do_stall &&
                    (eff_st == RUN) && bus.jump_in;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= RUN;
            ret_st_q   <= RUN;
            lu_cnt_q   <= 4'd0;
            wait_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_st_q   <= ret_st_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: freeze bookkeeping, branch abort, load-use countdown.
    always_comb begin
        state_d    = state_q;
        ret_st_d   = ret_st_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (do_freeze) begin
            state_d    = MEM_WAIT;
            ret_st_d   = eff_st;
            wait_cnt_d = in_wait ? sat_inc16(wait_cnt_q) : 16'd1;
            if (wait_cnt_d >= TIMEOUT_LIM) begin
                timeout_d = 1'b1;
            end
        end else if (do_branch) begin
            state_d  = RUN;
            lu_cnt_d = 4'd0;
        end else if (do_stall) begin
            if (eff_st == RUN) begin
                if (LU_STALL_CYCLES >= 2) begin
                    state_d  = LU_STALL;
                    lu_cnt_d = LU_RELOAD;
                end else begin
                    state_d = RUN;
                end
            end else begin
                lu_cnt_d = lu_cnt_q - 4'd1;
                state_d  = (lu_cnt_q == 4'd1) ? RUN : LU_STALL;
            end
        end else begin
            state_d = RUN;
        end
    end

    // Output decode from the arbitration result; reset forces the safe NOP-injecting pattern.
    always_comb begin
        pc_write     = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        hold         = 1'b0;
        if (do_freeze) begin
            pc_write = 1'b0;
            if_id_en = 1'b0;
            hold     = 1'b1;
        end else if (do_branch) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (do_stall) begin
            pc_write     = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (do_jump) begin
            if_id_flush = 1'b1;
        end

        if (reset_in) begin
            bus.PC_Write_out     = 1'b0;
            bus.IF_ID_enable_out = 1'b0;
            bus.IF_ID_flush_out  = 1'b1;
            bus.ID_EX_bubble_out = 1'b1;
            bus.pipe_hold_out    = 1'b0;
        end else begin
            bus.PC_Write_out     = pc_write;
            bus.IF_ID_enable_out = if_id_en;
            bus.IF_ID_flush_out  = if_id_flush;
            bus.ID_EX_bubble_out = id_ex_bubble;
            bus.pipe_hold_out    = hold;
        end
    end

    // Saturating statistics of stalled and flushed cycles.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (!pc_write) begin
                stall_cnt_q <= sat_inc16(stall_cnt_q);
            end
            if (if_id_flush) begin
                flush_cnt_q <= sat_inc16(flush_cnt_q);
            end
        end
    end

    assign bus.mem_timeout_out = timeout_q;
    assign bus.stall_count_out = stall_cnt_q;
    assign bus.flush_count_out = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a combinational vector table against a
// LU_STALL_CYCLES=1 / MEM_TIMEOUT=8 instance plus hand-written multi-cycle
// sequences on that instance and on a LU_STALL_CYCLES=3 instance.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] op;
        logic       mr;
        logic [4:0] exrt;
        logic       br;
        logic       jp;
        logic       busy;
    } in_t;

    // expected outputs packed as {PC_Write, IF_ID_enable, IF_ID_flush, ID_EX_bubble, pipe_hold}
    typedef struct {
        in_t        in;
        logic [4:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset_in;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    in_t  idle, hz, bubble_only, busy, jmp, jmp_hz, br_only;

    hazard_ctrl_if ifa();
    hazard_ctrl_if ifb();

    hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(8)) dut_a (
        .clk(clk), .reset_in(reset_in), .bus(ifa)
    );
    hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(8)) dut_b (
        .clk(clk), .reset_in(reset_in), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] op,
                               input logic mr, input logic [4:0] exrt, input logic br,
                               input logic jp, input logic bsy);
        in_t v;
        v.rs = rs; v.rt = rt; v.op = op; v.mr = mr; v.exrt = exrt;
        v.br = br; v.jp = jp; v.busy = bsy;
        return v;
    endfunction

    task automatic apply(input in_t v);
        ifa.IF_ID_Rs_in = v.rs;      ifb.IF_ID_Rs_in = v.rs;
        ifa.IF_ID_Rt_in = v.rt;      ifb.IF_ID_Rt_in = v.rt;
        ifa.Op_code_in = v.op;       ifb.Op_code_in = v.op;
        ifa.ID_EX_MemRead_in = v.mr; ifb.ID_EX_MemRead_in = v.mr;
        ifa.ID_EX_Rt_in = v.exrt;    ifb.ID_EX_Rt_in = v.exrt;
        ifa.branch_taken_in = v.br;  ifb.branch_taken_in = v.br;
        ifa.jump_in = v.jp;          ifb.jump_in = v.jp;
        ifa.mem_busy_in = v.busy;    ifb.mem_busy_in = v.busy;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs_a();
        return {ifa.PC_Write_out, ifa.IF_ID_enable_out, ifa.IF_ID_flush_out,
                ifa.ID_EX_bubble_out, ifa.pipe_hold_out};
    endfunction

    function automatic logic [4:0] outs_b();
        return {ifb.PC_Write_out, ifb.IF_ID_enable_out, ifb.IF_ID_flush_out,
                ifb.ID_EX_bubble_out, ifb.pipe_hold_out};
    endfunction

    // drive a new input set just after the falling edge and let it settle
    task automatic step(input in_t v);
        @(negedge clk);
        apply(v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_in = 1'b1;
        apply(idle);
        #2;
        reset_in = 1'b0;
    endtask

    initial begin
        idle        = mk(5'd0, 5'd0, 6'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        hz          = mk(5'd2, 5'd0, 6'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        bubble_only = mk(5'd2, 5'd0, 6'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        busy        = mk(5'd0, 5'd0, 6'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        jmp         = mk(5'd0, 5'd0, 6'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        jmp_hz      = mk(5'd2, 5'd0, 6'h00, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
        br_only     = mk(5'd0, 5'd0, 6'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

        tbl.push_back('{in: hz,                                                   exp: 5'b00010, name: "lu_rs"});
        tbl.push_back('{in: mk(5'd0, 5'd0, 6'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), exp: 5'b11000, name: "rt_zero"});
        tbl.push_back('{in: mk(5'd5, 5'd2, 6'h23, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0), exp: 5'b11000, name: "lw_in_id"});
        tbl.push_back('{in: mk(5'd5, 5'd2, 6'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0), exp: 5'b00010, name: "rtype_rt"});
        tbl.push_back('{in: mk(5'd5, 5'd2, 6'h2B, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0), exp: 5'b00010, name: "sw_rt"});
        tbl.push_back('{in: mk(5'd5, 5'd2, 6'h04, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0), exp: 5'b00010, name: "beq_rt"});
        tbl.push_back('{in: mk(5'd5, 5'd2, 6'h05, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0), exp: 5'b00010, name: "bne_rt"});
        tbl.push_back('{in: mk(5'd5, 5'd2, 6'h08, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0), exp: 5'b11000, name: "addi_rt"});
        tbl.push_back('{in: bubble_only,                                          exp: 5'b11000, name: "no_load"});
        tbl.push_back('{in: mk(5'd3, 5'd4, 6'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0), exp: 5'b11000, name: "reg_miss"});
        tbl.push_back('{in: br_only,                                              exp: 5'b11110, name: "branch"});
        tbl.push_back('{in: jmp,                                                  exp: 5'b11100, name: "jump"});
        tbl.push_back('{in: jmp_hz,                                               exp: 5'b00010, name: "jump_vs_lu"});
        tbl.push_back('{in: mk(5'd2, 5'd0, 6'h00, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0), exp: 5'b11110, name: "branch_vs_lu"});
        tbl.push_back('{in: busy,                                                 exp: 5'b00001, name: "mem_busy"});
        tbl.push_back('{in: mk(5'd2, 5'd0, 6'h00, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1), exp: 5'b00001, name: "busy_vs_all"});

        // power-on reset, observed before any clock edge
        reset_in = 1'b1;
        apply(idle);
        #2;
        check("reset_outs",    outs_a(), 5'b00110);
        check("reset_stall",   ifa.stall_count_out, 16'd0);
        check("reset_flush",   ifa.flush_count_out, 16'd0);
        check("reset_timeout", ifa.mem_timeout_out, 1'b0);
        reset_in = 1'b0;

        // single-cycle vector table, each vector followed by an idle cycle
        foreach (tbl[i]) begin
            step(tbl[i].in);
            check(tbl[i].name, outs_a(), tbl[i].exp);
            step(idle);
            check({tbl[i].name, "_after"}, outs_a(), 5'b11000);
        end

        // load-use with a single bubble cycle
        do_reset();
        step(hz);
        check("lu1_stall", outs_a(), 5'b00010);
        step(bubble_only);
        check("lu1_resume", outs_a(), 5'b11000);
        step(idle);
        check("lu1_stall_count", ifa.stall_count_out, 16'd1);

        // three-cycle load-use aborted by a taken branch in its second cycle
        do_reset();
        step(hz);
        check("lu3_first", outs_b(), 5'b00010);
        step(mk(5'd2, 5'd0, 6'h00, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0));
        check("lu3_branch", outs_b(), 5'b11110);
        step(idle);
        check("lu3_after_branch", outs_b(), 5'b11000);
        step(idle);
        check("lu3_br_stall_count", ifb.stall_count_out, 16'd1);
        check("lu3_br_flush_count", ifb.flush_count_out, 16'd1);

        // memory wait arriving in LU_STALL with two stall cycles left
        do_reset();
        step(hz);
        check("lu3w_first", outs_b(), 5'b00010);
        for (int k = 0; k < 4; k++) begin
            step(busy);
            check("lu3w_freeze", outs_b(), 5'b00001);
        end
        step(idle);
        check("lu3w_resume1", outs_b(), 5'b00010);
        step(idle);
        check("lu3w_resume2", outs_b(), 5'b00010);
        step(idle);
        check("lu3w_run", outs_b(), 5'b11000);
        step(idle);
        check("lu3w_stall_count", ifb.stall_count_out, 16'd7);

        // memory timeout after eight wait cycles, sticky until reset
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(busy);
            check("to_hold", outs_a(), 5'b00001);
            check("to_flag", ifa.mem_timeout_out, (k >= 9) ? 1'b1 : 1'b0);
        end
        step(idle);
        check("to_release", outs_a(), 5'b11000);
        check("to_sticky1", ifa.mem_timeout_out, 1'b1);
        step(idle);
        check("to_sticky2", ifa.mem_timeout_out, 1'b1);

        // asynchronous reset in the middle of a memory wait, between clock edges
        step(busy);
        step(busy);
        step(busy);
        #1;
        reset_in = 1'b1;
        #1;
        check("areset_outs",    outs_a(), 5'b00110);
        check("areset_stall",   ifa.stall_count_out, 16'd0);
        check("areset_flush",   ifa.flush_count_out, 16'd0);
        check("areset_timeout", ifa.mem_timeout_out, 1'b0);
        apply(idle);
        #1;
        reset_in = 1'b0;
        step(idle);
        check("areset_run", outs_a(), 5'b11000);
        check("areset_stall_after", ifa.stall_count_out, 16'd0);

        // jump coinciding with a load-use hazard, then a lone jump
        do_reset();
        step(jmp_hz);
        check("jlu_stall_wins", outs_a(), 5'b00010);
        step(jmp);
        check("jlu_jump", outs_a(), 5'b11100);
        step(idle);
        check("jlu_idle", outs_a(), 5'b11000);
        step(idle);
        check("jlu_flush_count", ifa.flush_count_out, 16'd1);
        check("jlu_stall_count", ifa.stall_count_out, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
